// File: rtl/dma_writeback.sv
// dma_writeback
//   Result write-back DMA. On an accepted start it reads NB result banks in
//   turn (bank 0 first) through a synchronous read port with 1-cycle latency.
//   It streams the words into ITCM at base, base+1, ... and honours the ITCM
//   ready handshake.
//
// Ports
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_wb_start          start request (accepted only in IDLE or DONE)
//   i_bank_length       words per bank, latched at start
//   i_itcm_base         first ITCM word address, latched at start
//   o_wb_busy           transfer in progress (READ or DRAIN)
//   o_wb_finish         sticky done flag, cleared by the next accepted start
//   o_bank_sel          one-hot bank being read (zero outside READ)
//   o_rd_en             bank read strobe
//   o_rd_addr           word address inside the selected bank
//   i_rd_data           read data, valid the cycle after o_rd_en
//   o_itcm_we           ITCM write request
//   o_itcm_addr         ITCM write address
//   o_itcm_wdata        ITCM write data
//   i_itcm_ready        ITCM accepts the write this cycle
//   o_dbg_state         current FSM state, for debug and checkers
//
// Handshake: an ITCM write transfers on every cycle where o_itcm_we and
// i_itcm_ready are both high. While o_itcm_we is high and ready is low,
// o_itcm_addr and o_itcm_wdata hold stable and o_itcm_we stays high.
module dma_writeback #(
    parameter int DW = 16,
    parameter int AW = 16,
    parameter int NB = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wb_start,
    input  logic [AW-1:0] i_bank_length,
    input  logic [AW-1:0] i_itcm_base,
    output logic          o_wb_busy,
    output logic          o_wb_finish,
    output logic [NB-1:0] o_bank_sel,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [DW-1:0] i_rd_data,
    output logic          o_itcm_we,
    output logic [AW-1:0] o_itcm_addr,
    output logic [DW-1:0] o_itcm_wdata,
    input  logic          i_itcm_ready,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [NB-1:0] bank_sel_q, bank_sel_d;
    logic          in_flight_q;

    logic [DW-1:0] fifo_mem_q [2];
    logic          fifo_wr_ptr_q;
    logic          fifo_rd_ptr_q;
    logic [1:0]    fifo_cnt_q;

    logic          push;
    logic          pop;
    logic          rd_en;
    logic          last_addr;
    logic          last_bank;
    logic [2:0]    occupancy;

    assign push      = in_flight_q;
    assign pop       = (fifo_cnt_q != 2'd0) && i_itcm_ready;
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b0, in_flight_q};

    // Credit check: a new read may issue only if every word already owed to
    // the FIFO, plus this one, fits in its two entries. This counts the
    // entries held, the read in flight and the entry that leaves this cycle.
    assign rd_en     = (state_q == S_READ) && (occupancy <= (3'd1 + {2'b0, pop}));

    assign last_addr = (rd_addr_q == (len_q - 1'b1));
    assign last_bank = bank_sel_q[NB-1];

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        base_d     = base_q;
        rd_addr_d  = rd_addr_q;
        bank_sel_d = bank_sel_q;
        wr_cnt_d   = pop ? (wr_cnt_q + 1'b1) : wr_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_wb_start) begin
                    len_d     = i_bank_length;
                    base_d    = i_itcm_base;
                    wr_cnt_d  = '0;
                    rd_addr_d = '0;
                    if (i_bank_length != '0) begin
                        state_d    = S_READ;
                        bank_sel_d = NB'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (rd_en) begin
                    if (last_addr) begin
                        // Move on to the next bank with no idle cycle.
                        rd_addr_d = '0;
                        if (last_bank) begin
                            bank_sel_d = '0;
                            state_d    = S_DRAIN;
                        end else begin
                            bank_sel_d = bank_sel_q << 1;
                        end
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Go to DONE on the edge that retires the last word, so finish
                // shows in the cycle right after the final acceptance.
                if (!in_flight_q &&
                    ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            base_q        <= '0;
            rd_addr_q     <= '0;
            wr_cnt_q      <= '0;
            bank_sel_q    <= '0;
            in_flight_q   <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            base_q      <= base_d;
            rd_addr_q   <= rd_addr_d;
            wr_cnt_q    <= wr_cnt_d;
            bank_sel_q  <= bank_sel_d;
            in_flight_q <= rd_en;
            if (push) begin
                fifo_mem_q[fifo_wr_ptr_q] <= i_rd_data;
                fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
            end
            if (pop) begin
                fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign o_wb_busy    = (state_q == S_READ) || (state_q == S_DRAIN);
    assign o_wb_finish  = (state_q == S_DONE);
    assign o_bank_sel   = bank_sel_q;
    assign o_rd_en      = rd_en;
    assign o_rd_addr    = rd_addr_q;
    assign o_itcm_we    = (fifo_cnt_q != 2'd0);
    assign o_itcm_addr  = base_q + wr_cnt_q;
    assign o_itcm_wdata = fifo_mem_q[fifo_rd_ptr_q];
    assign o_dbg_state  = state_q;

endmodule

// File: doc/dma_writeback.md
# dma_writeback

Result write-back DMA for the MNIST accelerator; it moves data in the opposite direction to the weight-load DMA. On start it reads NB on-chip result banks one after another through a synchronous read port with 1-cycle latency. It writes the words contiguously into ITCM starting at a programmable base, honouring an ITCM ready handshake. It sits between the accumulator result buffers and the ITCM write port, and the MNIST controller sequences it.

## Interface
- DW, 16, data width
- AW, 16, address width
- NB, 4, number of result banks (1..8)

- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_wb_start  in  1  start request, sampled in IDLE/DONE only
- i_bank_length  in  AW  words per bank, latched at start
- i_itcm_base  in  AW  first ITCM word address, latched at start
- o_wb_busy  out  1  high from the cycle after accepted start until finish
- o_wb_finish  out  1  sticky done, cleared by next accepted start
- o_bank_sel  out  NB  one-hot bank being read, valid with o_rd_en
- o_rd_en  out  1  result-bank read strobe
- o_rd_addr  out  AW  word address within the selected bank
- i_rd_data  in  DW  read data, valid the cycle after o_rd_en
- o_itcm_we  out  1  write request
- o_itcm_addr  out  AW  ITCM write address
- o_itcm_wdata  out  DW  ITCM write data
- i_itcm_ready  in  1  write accepted on a cycle with o_itcm_we && i_itcm_ready

## Operation
- States:
  - IDLE: start with len≠0 → READ; start with len==0 → DONE.
  - READ: issue reads bank 0..NB-1, addr 0..len-1; after the last issue → DRAIN.
  - DRAIN: wait until in-flight==0 and FIFO empty → DONE.
  - DONE: start → as from IDLE.
- Bank advance inside READ has no bubble: after addr len-1 of bank b, the next issue is addr 0 of bank b+1. o_bank_sel and o_rd_addr are registered together.
- 2-entry FIFO captures i_rd_data the cycle after each o_rd_en (in-flight counter 0..1).
- Issue rule (credit): o_rd_en=1 only when (fifo_count + in_flight − pop_now) ≤ 1, where pop_now = o_itcm_we && i_itcm_ready. The FIFO never overflows, and reads are never dropped.
- Write side:
  - o_itcm_we = FIFO non-empty; o_itcm_wdata = FIFO head.
  - o_itcm_addr = base + write_count, computed mod 2^AW (wraps silently).
  - write_count increments on each acceptance.
- ITCM order: bank0[0..len-1], bank1[0..len-1], …; word k of bank b lands at base + b·len + k.
- Arithmetic is AW-bit unsigned. NB·len overflowing 2^AW is not supported.
- i_wb_start while busy is ignored; latched length and base are unchanged.
- Reset values (all outputs): o_wb_busy, o_wb_finish, o_bank_sel, o_rd_en, o_rd_addr, o_itcm_we, o_itcm_addr, o_itcm_wdata = 0. FIFO empty, in-flight 0, state IDLE.
- Reset mid-operation: everything returns to reset values at the next edge. In-flight read data is discarded, and no further writes are issued.
- Outside READ, o_bank_sel=0 and o_rd_addr=0.

## Timing
- Edge E0 samples start. The first o_rd_en is in cycle 1 (after E0), and o_wb_busy goes high in cycle 1.
- Read issued in cycle k: data is on i_rd_data in cycle k+1 and pushed at the end of k+1. o_itcm_we is visible from cycle k+2.
- With i_itcm_ready held at 1 and N = NB·len:
  - reads occupy cycles 1..N and writes cycles 3..N+2, at one word per cycle;
  - o_wb_finish=1 and o_wb_busy=0 from cycle N+3.
- len==0: no reads or writes; o_wb_finish=1 in cycle 1 and o_wb_busy stays 0.
- i_itcm_ready low: the head word and address hold stable, o_itcm_we stays high, and reads throttle within one cycle. After ready returns, throughput recovers to 1 word per cycle.
- Finish is the cycle after the final write acceptance, never earlier.

## Test plan
- NB=4, len=4, base=0x0100, ready=1, bank b word k = 0xB0·(b+1)+k → 16 writes to 0x0100..0x010F in order; first we at cycle 3; finish at cycle 19; o_bank_sel steps 0001→1000.
- Same config, ready toggling 1,0,0,1 repeating → identical ITCM contents and order. Address/data stable while ready=0; rd_en never raised when fifo_count+in_flight would exceed 2.
- len=0, start → no rd_en, no we; finish=1 in cycle 1; a second start with len=2 runs normally and finish drops in cycle 1.
- base=0xFFFE, NB=2, len=2 → writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Start pulsed again mid-transfer with different len/base → ignored; original transfer completes unchanged.
- i_rst_n low at cycle 6 of a 16-word transfer → all outputs 0 at the next edge; no we afterwards; a fresh start after reset completes all 16 words correctly.
